// File: rtl/mmr_intr_pkg.sv
// mmr_intr_pkg: shared constants, address-map helpers and coalescing types for the
// register-side endpoint of the mmr_intr interface.
//   MMR_INTR_WORD_W     - width of one interrupt word
//   isr_addr/imr_addr   - word address of ISR[i] / IMR[i]
//   coal_cfg_addr       - word address of COAL_CFG for N interrupt words
//   COAL_* field bounds - bit positions of cnt_thr and timeout inside COAL_CFG
//   coal_state_t        - coalescing controller states
package mmr_intr_pkg;

    localparam int MMR_INTR_WORD_W = 32;

    localparam int COAL_FIELD_W       = 16;
    localparam int COAL_CNT_THR_LSB   = 0;
    localparam int COAL_CNT_THR_MSB   = 15;
    localparam int COAL_TIMEOUT_LSB   = 16;
    localparam int COAL_TIMEOUT_MSB   = 31;

    typedef enum logic [1:0] {
        COAL_IDLE   = 2'd0,
        COAL_HOLD   = 2'd1,
        COAL_ASSERT = 2'd2
    } coal_state_t;

    function automatic int isr_addr(input int i);
        return 2 * i;
    endfunction

    function automatic int imr_addr(input int i);
        return 2 * i + 1;
    endfunction

    function automatic int coal_cfg_addr(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/mmr_intr_coalesce.sv
// mmr_intr_coalesce: interrupt coalescing controller. Holds off irq until enough
// enabled events have been seen or a timeout expires after the first one.
//   clock_i, reset_i          - clock, synchronous active-high reset
//   any_enabled_event_i       - some enabled bit has a set pulse this cycle
//   any_enabled_pending_i     - some enabled bit is pending in ISR
//   cfg_i                     - current COAL_CFG word
//   cfg_wr_i, cfg_wr_timeout_i - COAL_CFG is being written, with the new timeout
//   irq_o                     - coalesced interrupt request
//
// state  | meaning
// IDLE   | nothing enabled is pending
// HOLD   | pending work, waiting for count threshold or timer expiry
// ASSERT | irq driven high until all enabled pending bits are cleared
module mmr_intr_coalesce
    import mmr_intr_pkg::*;
(
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    any_enabled_event_i,
    input  logic                    any_enabled_pending_i,
    input  logic [31:0]             cfg_i,
    input  logic                    cfg_wr_i,
    input  logic [COAL_FIELD_W-1:0] cfg_wr_timeout_i,
    output logic                    irq_o
);

    localparam logic [1:0] ST_IDLE   = COAL_IDLE;
    localparam logic [1:0] ST_HOLD   = COAL_HOLD;
    localparam logic [1:0] ST_ASSERT = COAL_ASSERT;

    logic [1:0]              state_q, state_d;
    logic [COAL_FIELD_W-1:0] cnt_q, cnt_d;
    logic [COAL_FIELD_W-1:0] timer_q, timer_d;
    logic [COAL_FIELD_W-1:0] thr;
    logic [COAL_FIELD_W-1:0] timeout;
    logic                    timer_expired;

    // A threshold of 0 would mean "assert before any event"; treat it as 1.
    assign thr = (cfg_i[COAL_CNT_THR_MSB:COAL_CNT_THR_LSB] == '0)
               ? COAL_FIELD_W'(1) : cfg_i[COAL_CNT_THR_MSB:COAL_CNT_THR_LSB];
    assign timeout       = cfg_i[COAL_TIMEOUT_MSB:COAL_TIMEOUT_LSB];
    assign timer_expired = (timeout != '0) && (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;

        // An event in the very cycle the last bit is cleared still counts.
        if (!any_enabled_pending_i && !any_enabled_event_i) begin
            cnt_d = '0;
        end else if (any_enabled_event_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!any_enabled_pending_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HOLD;
                    timer_d = timeout;
                end
                ST_HOLD: begin
                    if ((cnt_q >= thr) || timer_expired) begin
                        state_d = ST_ASSERT;
                    end else if (cfg_wr_i) begin
                        timer_d = cfg_wr_timeout_i;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_ASSERT: state_d = ST_ASSERT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    assign irq_o = (state_q == ST_ASSERT);

endmodule

// File: rtl/mmr_intr_regs.sv
// mmr_intr_regs: register-side endpoint of the mmr_intr interface. Owns the
// interrupt status (ISR, read / write-1-to-clear) and mask (IMR, read/write) words,
// accepts per-bit set pulses from the event side and drives a level irq.
//   clock_i, reset_i   - clock, synchronous active-high reset
//   isr_pulses_i       - one-cycle set pulses, word i at [32i+31:32i]
//   isr_o, imr_o       - current status / mask words
//   reg_wr_i, reg_rd_i - register port write / read strobes
//   reg_addr_i         - word address: 2i=ISR[i], 2i+1=IMR[i], 2N=COAL_CFG
//   reg_wdata_i        - write data
//   reg_rdata_o        - read data, one cycle after reg_rd_i
//   reg_rvalid_o       - one-cycle pulse per read
//   irq_o              - interrupt request, level
// Optional feature macro MMR_INTR_COALESCE_EN adds COAL_CFG and coalesced irq.
module mmr_intr_regs
    import mmr_intr_pkg::*;
#(
    parameter int N      = 1,
    parameter int ADDR_W = 5
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [N*MMR_INTR_WORD_W-1:0] isr_pulses_i,
    output logic [N*MMR_INTR_WORD_W-1:0] isr_o,
    output logic [N*MMR_INTR_WORD_W-1:0] imr_o,
    input  logic                         reg_wr_i,
    input  logic                         reg_rd_i,
    input  logic [ADDR_W-1:0]            reg_addr_i,
    input  logic [31:0]                  reg_wdata_i,
    output logic [31:0]                  reg_rdata_o,
    output logic                         reg_rvalid_o,
    output logic                         irq_o
);

    localparam int W = N * MMR_INTR_WORD_W;

    logic [W-1:0] isr_q, isr_d;
    logic [W-1:0] imr_q, imr_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         rvalid_q;

    // Clear first, then OR in pulses so a same-cycle pulse wins over W1C.
    always_comb begin
        isr_d = isr_q;
        imr_d = imr_q;
        for (int i = 0; i < N; i++) begin
            if (reg_wr_i && (reg_addr_i == ADDR_W'(isr_addr(i)))) begin
                isr_d[i*MMR_INTR_WORD_W +: MMR_INTR_WORD_W] =
                    isr_q[i*MMR_INTR_WORD_W +: MMR_INTR_WORD_W] & ~reg_wdata_i;
            end
            if (reg_wr_i && (reg_addr_i == ADDR_W'(imr_addr(i)))) begin
                imr_d[i*MMR_INTR_WORD_W +: MMR_INTR_WORD_W] = reg_wdata_i;
            end
        end
        isr_d = isr_d | isr_pulses_i;
    end

`ifdef MMR_INTR_COALESCE_EN
    logic [31:0] cfg_q;
    logic        cfg_wr;

    assign cfg_wr = reg_wr_i && (reg_addr_i == ADDR_W'(coal_cfg_addr(N)));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cfg_q <= 32'h0000_0001;
        end else if (cfg_wr) begin
            cfg_q <= reg_wdata_i;
        end
    end

    mmr_intr_coalesce u_coalesce (
        .clock_i               (clock_i),
        .reset_i               (reset_i),
        .any_enabled_event_i   (|(isr_pulses_i & imr_q)),
        .any_enabled_pending_i (|(isr_q & imr_q)),
        .cfg_i                 (cfg_q),
        .cfg_wr_i              (cfg_wr),
        .cfg_wr_timeout_i      (reg_wdata_i[COAL_TIMEOUT_MSB:COAL_TIMEOUT_LSB]),
        .irq_o                 (irq_o)
    );
`else
    logic irq_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(isr_q & imr_q);
        end
    end

    assign irq_o = irq_q;
`endif

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N; i++) begin
            if (reg_addr_i == ADDR_W'(isr_addr(i))) begin
                rdata_d = isr_q[i*MMR_INTR_WORD_W +: MMR_INTR_WORD_W];
            end
            if (reg_addr_i == ADDR_W'(imr_addr(i))) begin
                rdata_d = imr_q[i*MMR_INTR_WORD_W +: MMR_INTR_WORD_W];
            end
        end
`ifdef MMR_INTR_COALESCE_EN
        if (reg_addr_i == ADDR_W'(coal_cfg_addr(N))) begin
            rdata_d = cfg_q;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            isr_q    <= '0;
            imr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            rvalid_q <= reg_rd_i;
            if (reg_rd_i) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign isr_o        = isr_q;
    assign imr_o        = imr_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;

endmodule

// File: doc/mmr_intr_regs.md
Name: mmr_intr_regs

Overview:
- Register-side endpoint of the mmr_intr_interface.
- Owns the interrupt status (ISR) and interrupt mask (IMR) words; drives them toward the event side and accepts per-bit set pulses back from it.
- Software access is through a simple single-cycle register port: ISR is read / write-1-to-clear (W1C), IMR is read/write.
- Produces one level interrupt output to the host interrupt controller.

Parameters:
- N, 1, number of 32-bit interrupt words (1..8).
- ADDR_W, 5, register-port word-address width; must satisfy 2^ADDR_W >= 2*N+1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- isr_pulses  in  N*32  one-cycle set pulses from event sources; word i at bits [32i+31:32i]
- isr  out  N*32  current status words
- imr  out  N*32  current mask words (1 = enabled)
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_addr  in  ADDR_W  word address
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data
- reg_rvalid  out  1  read-data valid
- irq  out  1  interrupt request, level

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: isr=0, imr=0, reg_rdata=0, reg_rvalid=0, irq=0. A reset mid-operation discards pending pulses and in-flight reads.
- Address map:
  - 2i = ISR[i].
  - 2i+1 = IMR[i].
  - 2N = COAL_CFG (feature only).
  - Unmapped address: reads return 0, writes are ignored.
- ISR update per bit, per cycle: isr_next = (isr & ~w1c) | pulse.
  - w1c = reg_wdata when reg_wr targets that word, else 0.
  - Pulse and W1C on the same bit in the same cycle: set wins.
  - Pulses set ISR regardless of mask.
- IMR write takes effect on the next edge.
- Reads:
  - reg_rdata and reg_rvalid are registered with 1-cycle latency.
  - Read data is the value before any same-cycle write.
  - reg_rd and reg_wr in the same cycle are both performed.
  - reg_rvalid is a one-cycle pulse per reg_rd.
- Base irq (feature off): irq is registered = |(isr & imr) over all words. A pulse at edge t sets isr at t+1 and irq at t+2. Clearing the last enabled pending bit drops irq 2 cycles after the write cycle.
- Unmasking an already-pending bit raises irq 2 cycles after the IMR write.

Optional Feature:
- Macro: MMR_INTR_COALESCE_EN.
- Without the macro: base irq behaviour; COAL_CFG is unmapped.
- With the macro, COAL_CFG holds:
  - cnt_thr[15:0], reset 1.
  - timeout[31:16], reset 0; 0 means no timeout.
- Event counting: a 16-bit saturating event counter increments by 1 per cycle in which any enabled bit has a pulse (multiple bits in one cycle count once).
- FSM:
  - IDLE → HOLD on the first enabled pending event; the timer is loaded with timeout.
  - HOLD → ASSERT when count >= cnt_thr, or when the timer reaches 0 with timeout != 0.
  - ASSERT: irq=1.
  - ASSERT → IDLE when |(isr & imr) == 0; the counter clears.
  - Any state → IDLE when |(isr & imr) == 0.
- cnt_thr=0 is treated as 1.
- Writing COAL_CFG in HOLD restarts the timer.

Decomposition:
- Package mmr_intr_pkg:
  - MMR_INTR_WORD_W = 32.
  - Address offset functions isr_addr(i) and imr_addr(i).
  - COAL_CFG field positions.
  - Enum coal_state_t {IDLE, HOLD, ASSERT}.
- Sub-module mmr_intr_coalesce:
  - Inputs: any_enabled_event, any_enabled_pending, cfg.
  - Output: irq.
  - Instantiated only under MMR_INTR_COALESCE_EN.

Test Plan:
1. Reset, then read addr 0 and 1 → reg_rvalid one cycle later, reg_rdata 0; irq 0.
2. Write IMR[0]=0x1, pulse isr_pulses bit 0 at edge t → isr[0]=0x1 at t+1, irq=1 at t+2. Write ISR[0]=0x1 → irq back to 0 after 2 cycles.
3. Pulse bit 5 and write 0x20 to ISR[0] in the same cycle → bit 5 stays 1.
4. Pulse bit 3 with IMR=0 → isr=0x8, irq stays 0. Then write IMR=0x8 → irq=1 two cycles later.
5. N=2: pulse word 1 bit 31, read addr 2 → rdata 0x80000000. Read addr 7 (unmapped) → rdata 0.
6. MMR_INTR_COALESCE_EN, cnt_thr=3, timeout=0:
   - 2 enabled pulses → irq 0; the 3rd pulse → irq 1.
   - Then set cnt_thr=10, timeout=20: 1 pulse → irq 1 exactly after timer expiry.
